// File: rtl/npu_io_pkg.sv
// npu_io_pkg: config-word field positions and IEEE-754 single constants for the NPU input stage.
package npu_io_pkg;
  localparam int CFG_MODE_BIT = 15;
  localparam int CFG_SCALE_LSB = 0;
  localparam int CFG_SCALE_W = 8;
  localparam int FLT_EXP_BIAS = 127;
  localparam int FLT_MANT_W = 23;
  typedef enum logic {MODE_INT = 1'b0, MODE_FLOAT = 1'b1} mode_e;
endpackage

// File: rtl/npu_sync_fifo.sv
// npu_sync_fifo: first-word-fall-through FIFO with occupancy count and full/empty flags.
module npu_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int OUT_W = 16
) (
  input  logic                     CLK,
  input  logic                     npu_rst_n,
  input  logic                     push,
  input  logic [OUT_W-1:0]         din,
  input  logic                     pop,
  output logic [OUT_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge CLK)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge CLK) begin
    if (!npu_rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/npu_input_stage.sv
// npu_input_stage: int/float host words to saturated fixed point, 2-stage pipeline into a FWFT FIFO.
module npu_input_stage
  import npu_io_pkg::*;
#(
  parameter int IN_W = 32,
  parameter int OUT_W = 16,
  parameter int FRAC_W = 7,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     npu_rst_n,
  input  logic                     cfg_wr_en,
  input  logic [15:0]              cfg_data,
  input  logic                     sat_clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     sat_flag
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = IN_W + OUT_W + 1;
  localparam int FW = FLT_MANT_W + OUT_W + 2;
  localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [IW-1:0] IMAX = {{(IW-OUT_W){1'b0}}, MAXV};
  localparam logic signed [IW-1:0] IMIN = ~IMAX;
  localparam logic [FW-1:0] FLIM = {{(FW-OUT_W){1'b0}}, MINV};
  localparam logic signed [9:0] FOFF = 10'(FLT_EXP_BIAS + FLT_MANT_W);
  mode_e cfg_mode, s1_mode;
  logic [CFG_SCALE_W-1:0] cfg_scale, s1_scale;
  logic [IN_W-1:0] s1_data;
  logic s1_v, s2_v, s2_sat;
  logic [OUT_W-1:0] s2_data;
  logic cfg_unused;
  logic [CW:0] credit;
  logic signed [9:0] k, fs;
  logic signed [IW-1:0] iv;
  logic [FW-1:0] fm;
  logic [7:0] fe;
  logic f_neg, f_nan, f_ovf, i_hi, i_lo, csat;
  logic [OUT_W-1:0] cv, fval, ival;
  assign cfg_unused = ^cfg_data[14:8];
  // Credits count words already in flight so the FIFO can never overflow.
  assign credit = {1'b0, fifo_count} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
  assign in_ready = credit < (CW+1)'(DEPTH);
  assign out_valid = !fifo_empty;
  // Shift amounts are clamped so oversize shifts saturate or zero instead of wrapping.
  always_comb begin
    k = $signed({{(10-CFG_SCALE_W){s1_scale[CFG_SCALE_W-1]}}, s1_scale}) + 10'(FRAC_W);
    iv = {{(IW-IN_W){s1_data[IN_W-1]}}, s1_data};
    iv = k[9] ? iv >>> ((-k > 10'(IN_W)) ? 10'(IN_W) : -k) : iv <<< ((k > 10'(OUT_W)) ? 10'(OUT_W) : k);
    i_hi = iv > IMAX;
    i_lo = iv < IMIN;
    ival = i_hi ? MAXV : i_lo ? MINV : iv[OUT_W-1:0];
    fe = s1_data[30:23];
    f_neg = s1_data[31];
    f_nan = fe == 8'hFF && s1_data[FLT_MANT_W-1:0] != '0;
    fs = $signed({2'b00, fe}) - FOFF + k;
    fm = {{(FW-FLT_MANT_W-1){1'b0}}, 1'b1, s1_data[FLT_MANT_W-1:0]};
    fm = fs[9] ? fm >> ((-fs > 10'sd24) ? 10'sd24 : -fs) : fm << ((fs > 10'(OUT_W)) ? 10'(OUT_W) : fs);
    f_ovf = f_neg ? fm > FLIM : fm >= FLIM;
    fval = f_neg ? -fm[OUT_W-1:0] : fm[OUT_W-1:0];
    cv = s1_mode == MODE_FLOAT ? (fe == 8'h00 ? '0 : (fe == 8'hFF || f_ovf) ? ((f_neg && !f_nan) ? MINV : MAXV) : fval) : ival;
    csat = s1_mode == MODE_FLOAT ? (fe == 8'hFF || (fe != 8'h00 && f_ovf)) : (i_hi || i_lo);
  end
  always_ff @(posedge CLK) begin
    if (!npu_rst_n) begin
      cfg_mode <= MODE_INT;
      cfg_scale <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s2_sat <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (cfg_wr_en) begin
        cfg_mode <= mode_e'(cfg_data[CFG_MODE_BIT]);
        cfg_scale <= cfg_data[CFG_SCALE_LSB +: CFG_SCALE_W];
      end
      s1_v <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_data <= in_data;
        s1_mode <= cfg_mode;
        s1_scale <= cfg_scale;
      end
      s2_v <= s1_v;
      s2_data <= cv;
      s2_sat <= s1_v && csat;
      sat_flag <= (s2_v && s2_sat) || (sat_flag && !sat_clr);
    end
  end
  npu_sync_fifo #(.DEPTH(DEPTH), .OUT_W(OUT_W)) u_fifo (
    .CLK(CLK),
    .npu_rst_n(npu_rst_n),
    .push(s2_v),
    .din(s2_data),
    .pop(out_ready),
    .dout(out_data),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule
